// File: rtl/rr_mux_pkg.sv
// Shared types and constants for the round-robin 8:1 gathering mux.
// Latency: n/a (types only).
// Backpressure: n/a.
package rr_mux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] sel_t;

  // Output register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_mux_8_1_if.sv
// Handshake bundle of rr_mux_8_1: 8 source channels in, one tagged stream out.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry the valid-ready stall in each direction.
interface rr_mux_8_1_if #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
);
  import rr_mux_pkg::*;

  logic [NUM_CH-1:0]    in_valid;
  logic [NUM_CH*DW-1:0] in_data;
  logic [NUM_CH-1:0]    in_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  sel_t                 out_sel;
  logic                 out_ready;
  logic [CNT_W-1:0]     xfer_count;

  // Sources plus sink: drives channel inputs and out_ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, xfer_count
  );

  // The mux itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, xfer_count
  );

endinterface

// File: rtl/rr_pick_8.sv
// Rotating-priority finder: first set req bit at or after ptr, wrapping 7->0.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the grant is used.
module rr_pick_8
  import rr_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output sel_t              gnt_idx,
  output logic [NUM_CH-1:0] gnt_onehot,
  output logic              any
);

  logic found;
  sel_t cand;

  // Walk ptr, ptr+1, ... ptr+7; the 3-bit add supplies the modulo-8 wrap.
  always_comb begin
    found   = 1'b0;
    cand    = '0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = ptr + sel_t'(k);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Expand the winning index; zero when nobody requests so it never mis-grants.
  always_comb begin
    any        = |req;
    gnt_onehot = any ? (NUM_CH'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/rr_mux_8_1.sv
// Registered 8:1 round-robin mux tagging each word with its source channel.
// Latency: 1 cycle from in_valid&in_ready to out_valid; 1 word/cycle sustained.
// Backpressure: full output register with out_ready=0 holds and drops in_ready to 0.
module rr_mux_8_1
  import rr_mux_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_mux_8_1_if.slave  bus
);

  state_t            state_q;
  state_t            state_d;
  sel_t              ptr;
  sel_t              gnt_idx;
  logic [NUM_CH-1:0] gnt_onehot;
  logic              any_v;
  logic              load;
  logic [DW-1:0]     data_q;
  sel_t              sel_q;
  logic [CNT_W-1:0]  xfer_q;
  logic              accept;

  rr_pick_8 u_pick (
    .req        (bus.in_valid),
    .ptr        (ptr),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .any        (any_v)
  );

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Fill on load; drain only when the sink takes the word and nothing replaces it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (!load && bus.out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs; rst_n gating keeps in_ready low while reset is held.
  always_comb begin
    bus.out_valid = (state_q == FULL);
    accept        = (state_q == FULL) && bus.out_ready;
    load          = rst_n && any_v && ((state_q == EMPTY) || bus.out_ready);
    bus.in_ready  = load ? gnt_onehot : '0;
  end

  // Capture the granted word and advance the round-robin start past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      sel_q  <= '0;
      ptr    <= '0;
    end else if (load) begin
      data_q <= bus.in_data[gnt_idx*DW +: DW];
      sel_q  <= gnt_idx;
      ptr    <= gnt_idx + sel_t'(1);
    end
  end

  // Count words taken by the sink; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      xfer_q <= '0;
    else if (accept) xfer_q <= xfer_q + CNT_W'(1);
  end

  assign bus.out_data   = data_q;
  assign bus.out_sel    = sel_q;
  assign bus.xfer_count = xfer_q;

endmodule
